// File: rtl/io_uart_tx_pkg.sv
// Shared IO definitions for the UART transmitter: register map, CTRL bits,
// FSM encoding and divisor defaults.
package io_uart_tx_pkg;

  localparam logic [31:0] AddrTxData = 32'h0100_0000;
  localparam logic [31:0] AddrDiv    = 32'h0100_0004;
  localparam logic [31:0] AddrCtrl   = 32'h0100_0008;

  localparam int unsigned CtrlClrOvfBit = 0;
  localparam int unsigned CtrlFlushBit  = 1;

  localparam logic [15:0] DefaultResetDiv = 16'd434;
  localparam logic [15:0] MinDiv          = 16'd2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // A one-clock bit time cannot hold the timer's compare, so small values are raised.
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < MinDiv) ? MinDiv : div;
  endfunction

endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers, separate occupancy count and flush.
module io_uart_tx_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

  // Next-state for pointers and count; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: register decode, divisor, bit timer and frame FSM
// in front of a byte FIFO.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] RESET_DIV  = DefaultResetDiv
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        io_en,
  output logic        tx,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        tx_busy,
  output logic        overflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic            wr_txdata, wr_div, wr_ctrl;
  logic            flush, clr_ovf, fifo_push, fifo_pop;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] frame_div_q, frame_div_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic        timer_done;

  assign wr_txdata = io_en && (addr == AddrTxData);
  assign wr_div    = io_en && (addr == AddrDiv);
  assign wr_ctrl   = io_en && (addr == AddrCtrl);
  assign flush     = wr_ctrl && wdata[CtrlFlushBit];
  assign clr_ovf   = wr_ctrl && wdata[CtrlClrOvfBit];

  // A flushing cycle neither loads a byte nor starts a frame.
  assign fifo_push = wr_txdata && !flush;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty && !flush;

  io_uart_tx_sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .flush_i(flush),
    .push_i (fifo_push),
    .wdata_i(wdata[7:0]),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Divisor and sticky overflow next-state from register writes.
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div) div_d = clamp_div(wdata[15:0]);
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (clr_ovf) ovf_d = 1'b0;
  end

  assign timer_done = (timer_q == frame_div_q - 16'd1);

  // Frame FSM next-state; tx_d follows the current state so tx trails it by one clock.
  always_comb begin
    state_d     = state_q;
    frame_div_d = frame_div_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tx_d        = 1'b1;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (fifo_pop) begin
          shreg_d     = fifo_rdata;
          frame_div_d = div_q;
          timer_d     = '0;
          bit_cnt_d   = '0;
          state_d     = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (timer_done) begin
          timer_d = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StData: begin
        tx_d = shreg_q[0];
        if (timer_done) begin
          timer_d = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (timer_done) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      div_q       <= RESET_DIV;
      frame_div_q <= RESET_DIV;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      frame_div_q <= frame_div_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != StIdle);
  assign overflow = ovf_q;

  logic unused_sig;
  assign unused_sig = ^{fifo_count, wdata[31:16]};

endmodule
